// File: rtl/clock_pkg.sv
// Shared widths, field limits and time record for the wall-clock counter.
package clock_pkg;

    localparam int SEC_BIT  = 6;
    localparam int MIN_BIT  = 6;
    localparam int HOUR_BIT = 5;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef struct packed {
        logic [HOUR_BIT-1:0] hour;
        logic [MIN_BIT-1:0]  min;
        logic [SEC_BIT-1:0]  sec;
    } time_t;

    // True when a candidate hh:mm:ss lies inside the 24 h clock range.
    function automatic logic time_in_range(input int hour, input int min, input int sec);
        return (hour <= HOUR_MAX) && (min <= MIN_MAX) && (sec <= SEC_MAX);
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Loadable modulo-(MAX+1) counter; o_wrap is a combinational carry for chaining.
module mod_n_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_val,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    // Next value: load wins over increment; increment wraps at MAX, not 2^WIDTH.
    always_comb begin
        val_d = val_q;
        if (i_load) begin
            val_d = i_load_val;
        end else if (i_inc) begin
            if (val_q == MAX_V) begin
                val_d = {WIDTH{1'b0}};
            end else begin
                val_d = val_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            val_d = val_q;
        end
    end

    // Field register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= {WIDTH{1'b0}};
        end else begin
            val_q <= val_d;
        end
    end

    assign o_val  = val_q;
    assign o_wrap = i_inc & ~i_load & (val_q == MAX_V);

endmodule

// File: rtl/clock_time_counter.sv
// 24 h hh:mm:ss time keeper driven by a 1 Hz tick, with load, carry pulses and range-checked set.
// Optional alarm register and match pulse are built when CLOCK_TIME_ALARM_EN is defined.
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int P_SEC_BIT  = SEC_BIT,
    parameter int P_MIN_BIT  = MIN_BIT,
    parameter int P_HOUR_BIT = HOUR_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  i_tick,
    input  logic                  i_set,
    input  logic [P_HOUR_BIT-1:0] i_set_hour,
    input  logic [P_MIN_BIT-1:0]  i_set_min,
    input  logic [P_SEC_BIT-1:0]  i_set_sec,
    input  logic                  i_alarm_set,
    input  logic                  i_alarm_en,
    output logic [P_SEC_BIT-1:0]  o_sec,
    output logic [P_MIN_BIT-1:0]  o_min,
    output logic [P_HOUR_BIT-1:0] o_hour,
    output logic                  o_min_tick,
    output logic                  o_hour_tick,
    output logic                  o_day_tick,
    output logic                  o_set_err,
    output logic                  o_alarm
);

    logic                  set_valid_s;
    logic                  load_s;
    logic                  inc_sec_s;
    logic                  sec_wrap_s;
    logic                  min_wrap_s;
    logic                  hour_wrap_s;
    logic [P_SEC_BIT-1:0]  sec_s;
    logic [P_MIN_BIT-1:0]  min_s;
    logic [P_HOUR_BIT-1:0] hour_s;

    logic min_tick_q,  min_tick_d;
    logic hour_tick_q, hour_tick_d;
    logic day_tick_q,  day_tick_d;
    logic set_err_q,   set_err_d;

    assign set_valid_s = time_in_range(int'(i_set_hour), int'(i_set_min), int'(i_set_sec));
    assign load_s      = i_set & set_valid_s;
    // A valid load swallows any tick on the same edge.
    assign inc_sec_s   = en & i_tick & ~load_s;

    mod_n_counter #(.WIDTH(P_SEC_BIT), .MAX(SEC_MAX)) u_sec (
        .clk        (clk),
        .reset      (reset),
        .i_load     (load_s),
        .i_load_val (i_set_sec),
        .i_inc      (inc_sec_s),
        .o_val      (sec_s),
        .o_wrap     (sec_wrap_s)
    );

    mod_n_counter #(.WIDTH(P_MIN_BIT), .MAX(MIN_MAX)) u_min (
        .clk        (clk),
        .reset      (reset),
        .i_load     (load_s),
        .i_load_val (i_set_min),
        .i_inc      (sec_wrap_s),
        .o_val      (min_s),
        .o_wrap     (min_wrap_s)
    );

    mod_n_counter #(.WIDTH(P_HOUR_BIT), .MAX(HOUR_MAX)) u_hour (
        .clk        (clk),
        .reset      (reset),
        .i_load     (load_s),
        .i_load_val (i_set_hour),
        .i_inc      (min_wrap_s),
        .o_val      (hour_s),
        .o_wrap     (hour_wrap_s)
    );

    // Carry pulses land on the same edge that writes the wrapped field value.
    always_comb begin
        min_tick_d  = sec_wrap_s;
        hour_tick_d = min_wrap_s;
        day_tick_d  = hour_wrap_s;
`ifdef CLOCK_TIME_ALARM_EN
        set_err_d   = (i_set | i_alarm_set) & ~set_valid_s;
`else
        set_err_d   = i_set & ~set_valid_s;
`endif
    end

    // Pulse output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            min_tick_q  <= min_tick_d;
            hour_tick_q <= hour_tick_d;
            day_tick_q  <= day_tick_d;
            set_err_q   <= set_err_d;
        end
    end

`ifdef CLOCK_TIME_ALARM_EN
    logic [P_SEC_BIT-1:0]  alarm_sec_q,  alarm_sec_d;
    logic [P_MIN_BIT-1:0]  alarm_min_q,  alarm_min_d;
    logic [P_HOUR_BIT-1:0] alarm_hour_q, alarm_hour_d;
    logic                  alarm_hit_q,  alarm_hit_d;
    logic [P_SEC_BIT-1:0]  nxt_sec_s;
    logic [P_MIN_BIT-1:0]  nxt_min_s;
    logic [P_HOUR_BIT-1:0] nxt_hour_s;

    // Time that a count step will produce, so the match pulse aligns with the updated time.
    always_comb begin
        nxt_sec_s  = sec_s;
        nxt_min_s  = min_s;
        nxt_hour_s = hour_s;
        if (sec_wrap_s) begin
            nxt_sec_s = {P_SEC_BIT{1'b0}};
        end else begin
            nxt_sec_s = sec_s + {{(P_SEC_BIT-1){1'b0}}, 1'b1};
        end
        if (min_wrap_s) begin
            nxt_min_s = {P_MIN_BIT{1'b0}};
        end else if (sec_wrap_s) begin
            nxt_min_s = min_s + {{(P_MIN_BIT-1){1'b0}}, 1'b1};
        end else begin
            nxt_min_s = min_s;
        end
        if (hour_wrap_s) begin
            nxt_hour_s = {P_HOUR_BIT{1'b0}};
        end else if (min_wrap_s) begin
            nxt_hour_s = hour_s + {{(P_HOUR_BIT-1){1'b0}}, 1'b1};
        end else begin
            nxt_hour_s = hour_s;
        end
    end

    // Alarm register load and match detection; loads never raise the alarm.
    always_comb begin
        alarm_sec_d  = alarm_sec_q;
        alarm_min_d  = alarm_min_q;
        alarm_hour_d = alarm_hour_q;
        if (i_alarm_set & set_valid_s) begin
            alarm_sec_d  = i_set_sec;
            alarm_min_d  = i_set_min;
            alarm_hour_d = i_set_hour;
        end else begin
            alarm_sec_d  = alarm_sec_q;
            alarm_min_d  = alarm_min_q;
            alarm_hour_d = alarm_hour_q;
        end
        alarm_hit_d = inc_sec_s & i_alarm_en & (nxt_sec_s == alarm_sec_q) &
                      (nxt_min_s == alarm_min_q) & (nxt_hour_s == alarm_hour_q);
    end

    // Alarm state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_sec_q  <= {P_SEC_BIT{1'b0}};
            alarm_min_q  <= {P_MIN_BIT{1'b0}};
            alarm_hour_q <= {P_HOUR_BIT{1'b0}};
            alarm_hit_q  <= 1'b0;
        end else begin
            alarm_sec_q  <= alarm_sec_d;
            alarm_min_q  <= alarm_min_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_hit_q  <= alarm_hit_d;
        end
    end

    assign o_alarm = alarm_hit_q;
`else
    logic unused_alarm_s;
    assign unused_alarm_s = i_alarm_set ^ i_alarm_en;
    assign o_alarm        = 1'b0;
`endif

    assign o_sec       = sec_s;
    assign o_min       = min_s;
    assign o_hour      = hour_s;
    assign o_min_tick  = min_tick_q;
    assign o_hour_tick = hour_tick_q;
    assign o_day_tick  = day_tick_q;
    assign o_set_err   = set_err_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed plus random bench for clock_time_counter against a seconds-of-day reference model.
module tb_clock_time_counter;

`ifdef CLOCK_TIME_ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_set = 1'b0;
    logic [4:0] i_set_hour = 5'd0;
    logic [5:0] i_set_min = 6'd0;
    logic [5:0] i_set_sec = 6'd0;
    logic       i_alarm_set = 1'b0;
    logic       i_alarm_en = 1'b0;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_min_tick, o_hour_tick, o_day_tick, o_set_err, o_alarm;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: seconds since midnight and alarm time in seconds.
    int t_ref = 0;
    int alarm_ref = 0;

    clock_time_counter dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .i_tick      (i_tick),
        .i_set       (i_set),
        .i_set_hour  (i_set_hour),
        .i_set_min   (i_set_min),
        .i_set_sec   (i_set_sec),
        .i_alarm_set (i_alarm_set),
        .i_alarm_en  (i_alarm_en),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_hour      (o_hour),
        .o_min_tick  (o_min_tick),
        .o_hour_tick (o_hour_tick),
        .o_day_tick  (o_day_tick),
        .o_set_err   (o_set_err),
        .o_alarm     (o_alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic step(input bit rst_v, input bit en_v, input bit tick_v, input bit set_v,
                        input bit aset_v, input bit aen_v, input int hh, input int mm, input int ss);
        bit valid;
        bit e_min, e_hour, e_day, e_err, e_alarm;
        reset       = rst_v;
        en          = en_v;
        i_tick      = tick_v;
        i_set       = set_v;
        i_alarm_set = aset_v;
        i_alarm_en  = aen_v;
        i_set_hour  = 5'(hh);
        i_set_min   = 6'(mm);
        i_set_sec   = 6'(ss);
        @(posedge clk);
        valid = (hh <= 23) && (mm <= 59) && (ss <= 59);
        {e_min, e_hour, e_day, e_err, e_alarm} = 5'b0;
        if (rst_v) begin
            t_ref     = 0;
            alarm_ref = 0;
        end else begin
            e_err = (set_v || (ALARM && aset_v)) && !valid;
            if (set_v && valid) begin
                t_ref = hh * 3600 + mm * 60 + ss;
            end else if (en_v && tick_v) begin
                t_ref   = (t_ref + 1) % 86400;
                e_min   = (t_ref % 60) == 0;
                e_hour  = (t_ref % 3600) == 0;
                e_day   = t_ref == 0;
                e_alarm = ALARM && aen_v && (t_ref == alarm_ref);
            end
            if (ALARM && aset_v && valid) alarm_ref = hh * 3600 + mm * 60 + ss;
        end
        #1;
        chk("sec",       int'(o_sec),  t_ref % 60);
        chk("min",       int'(o_min),  (t_ref / 60) % 60);
        chk("hour",      int'(o_hour), t_ref / 3600);
        chk("min_tick",  int'(o_min_tick),  int'(e_min));
        chk("hour_tick", int'(o_hour_tick), int'(e_hour));
        chk("day_tick",  int'(o_day_tick),  int'(e_day));
        chk("set_err",   int'(o_set_err),   int'(e_err));
        chk("alarm",     int'(o_alarm),     int'(e_alarm));
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        // 60 ticks: seconds roll into the first minute
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        // End-of-day rollover
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 23, 59, 58);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        // Rejected set, then set colliding with a tick
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12, 60, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12, 34, 56);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24, 0, 0);
        // Hold with en=0, then three back-to-back ticks
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        // Reset mid-count with a tick on the same edge
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5, 6, 7);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        // Alarm at 00:00:03: armed, disarmed, and reached by a load
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 60, 3);
        // Randomized traffic, biased toward wrap points
        for (int i = 0; i < 400; i++) begin
            bit r_set, r_aset, near;
            int hh, mm, ss;
            r_set  = ($urandom_range(0, 15) == 0);
            r_aset = ($urandom_range(0, 15) == 0);
            near   = ($urandom_range(0, 1) == 1);
            hh = near ? $urandom_range(22, 24) : $urandom_range(0, 31);
            mm = near ? $urandom_range(58, 60) : $urandom_range(0, 63);
            ss = near ? $urandom_range(57, 60) : $urandom_range(0, 63);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
                 r_set, r_aset, $urandom_range(0, 1) == 1, hh, mm, ss);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
